// File: rtl/tick_pkg.sv
// Shared types and default constants for the tick burst generator.
package tick_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tick_state_e;

  localparam int TICK_DIV_DEF   = 10;
  localparam int TICK_CNT_W_DEF = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 prescaler with synchronous clear and count enable.
// wrap is high in the cycle the counter sits at DIV-1 while enabled.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign wrap = en && (cnt == LAST);

  // Count while enabled, wrap to zero after DIV-1; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_burst_gen.sv
// Programmable burst of single-cycle enable ticks spaced DIV clocks apart,
// with start/stop/done handshake.
//
// state | meaning
// IDLE  | waiting for start; burst_len sampled on accept
// RUN   | prescaler running, one tick per DIV clocks
// DONE  | burst finished or aborted; one cycle, then back to IDLE
module tick_burst_gen
  import tick_pkg::*;
#(
  parameter int DIV   = TICK_DIV_DEF,
  parameter int CNT_W = TICK_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] burst_len,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt
);

  if (DIV < 2) begin : g_div_check
    $fatal(1, "tick_burst_gen: DIV must be at least 2");
  end

  tick_state_e      state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_next;
  logic             pre_clr;
  logic             pre_en;
  logic             pre_wrap;

  assign pre_clr  = (state == IDLE) && start;
  assign pre_en   = (state == RUN);
  assign cnt_next = tick_cnt + 1'b1;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pre_clr),
    .en    (pre_en),
    .wrap  (pre_wrap)
  );

  // Burst sequencing FSM with registered tick/busy/done/tick_cnt.
  // A zero-length burst raises done on entry to DONE so it appears one cycle
  // after the accepting edge; a normal burst raises done on leaving DONE.
  // done already high inside DONE therefore marks the zero-length path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      tick     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            len_q    <= burst_len;
            tick_cnt <= '0;
            if (burst_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pre_wrap) begin
            tick     <= 1'b1;
            tick_cnt <= cnt_next;
            if ((cnt_next == len_q) || stop) begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end else if (stop) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= ~done;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_burst_gen.sv
// Scoreboard bench for tick_burst_gen: expected tick/done events are queued
// when a burst is launched and checked as the DUT emits them.
module tb_tick_burst_gen;

  localparam int DIV   = 10;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic             tick;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] tick_cnt;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  typedef struct {
    int e;
    int cnt;
  } tick_exp_t;

  tick_exp_t tick_q[$];
  int        done_q[$];
  tick_exp_t mon_te;
  int        mon_de;

  tick_burst_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .tick_cnt  (tick_cnt)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Consumer side of the scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tick) begin
        vectors++;
        if (tick_q.size() == 0) begin
          miscompares++;
          $display("FAIL tick_extra: tick at edge %0d cnt=%0d, expected no tick", edge_n, tick_cnt);
        end else begin
          mon_te = tick_q.pop_front();
          if (edge_n !== mon_te.e || tick_cnt !== CNT_W'(mon_te.cnt)) begin
            miscompares++;
            $display("FAIL tick_event: got edge %0d cnt=%0d, expected edge %0d cnt=%0d",
                     edge_n, tick_cnt, mon_te.e, mon_te.cnt);
          end
        end
      end
      if (done) begin
        vectors++;
        if (done_q.size() == 0) begin
          miscompares++;
          $display("FAIL done_extra: done at edge %0d, expected no done", edge_n);
        end else begin
          mon_de = done_q.pop_front();
          if (edge_n !== mon_de) begin
            miscompares++;
            $display("FAIL done_event: got edge %0d, expected edge %0d", edge_n, mon_de);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  // Drive start on the next edge and queue the expected events.
  // stop_rel < 0 means no stop; otherwise the caller drives stop at e0+stop_rel.
  task automatic launch(input int len, input int stop_rel);
    int e0;
    int last;
    start     = 1'b1;
    burst_len = CNT_W'(len);
    e0        = edge_n + 1;
    for (int k = 1; k <= len; k++) begin
      if (stop_rel < 0 || k * DIV <= stop_rel) tick_q.push_back('{e0 + k * DIV, k});
    end
    if (len == 0) begin
      done_q.push_back(e0);
    end else begin
      last = len * DIV;
      if (stop_rel >= 0 && stop_rel < last) last = stop_rel;
      done_q.push_back(e0 + last + 1);
    end
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (tick_q.size() == 0 && done_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    repeat (2) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b, expected 0", tick); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, expected 0", done); end
    vectors++;
    if (tick_cnt !== '0) begin miscompares++; $display("FAIL reset_cnt: got %0d, expected 0", tick_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic test_basic();
    launch(3, -1);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_rise: got %b, expected 1", busy); end
    drain(60);
    vectors++;
    if (tick_q.size() + done_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_pending: %0d events outstanding, expected 0", tick_q.size() + done_q.size());
    end
    vectors++;
    if (tick_cnt !== 8'd3) begin miscompares++; $display("FAIL basic_cnt_hold: got %0d, expected 3", tick_cnt); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_fall: got %b, expected 0", busy); end
  endtask

  task automatic test_zero_len();
    logic seen_busy;
    launch(0, -1);
    seen_busy = busy;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      seen_busy = seen_busy | busy;
    end
    vectors++;
    if (seen_busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b, expected 0", seen_busy); end
    vectors++;
    if (tick_cnt !== '0) begin miscompares++; $display("FAIL zero_cnt: got %0d, expected 0", tick_cnt); end
    vectors++;
    if (tick_q.size() + done_q.size() != 0) begin
      miscompares++;
      $display("FAIL zero_pending: %0d events outstanding, expected 0", tick_q.size() + done_q.size());
    end
  endtask

  task automatic test_stop(input int len, input int stop_rel, input int exp_cnt);
    launch(len, stop_rel);
    repeat (stop_rel - 1) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    #1;
    drain(80);
    vectors++;
    if (tick_cnt !== CNT_W'(exp_cnt)) begin
      miscompares++;
      $display("FAIL stop_cnt len=%0d stop=%0d: got %0d, expected %0d", len, stop_rel, tick_cnt, exp_cnt);
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL stop_busy: got %b, expected 0", busy); end
    vectors++;
    if (tick_q.size() + done_q.size() != 0) begin
      miscompares++;
      $display("FAIL stop_pending: %0d events outstanding, expected 0", tick_q.size() + done_q.size());
    end
  endtask

  task automatic test_back_to_back();
    launch(3, -1);
    repeat (14) @(negedge clk);
    start     = 1'b1;
    burst_len = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    start     = 1'b1;
    burst_len = 8'd7;
    @(negedge clk);
    #1;
    launch(2, -1);
    vectors++;
    if (tick_cnt !== '0) begin miscompares++; $display("FAIL restart_cnt: got %0d, expected 0", tick_cnt); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy: got %b, expected 1", busy); end
    drain(60);
    vectors++;
    if (tick_cnt !== 8'd2) begin miscompares++; $display("FAIL restart_final_cnt: got %0d, expected 2", tick_cnt); end
    vectors++;
    if (tick_q.size() + done_q.size() != 0) begin
      miscompares++;
      $display("FAIL restart_pending: %0d events outstanding, expected 0", tick_q.size() + done_q.size());
    end
  endtask

  task automatic test_async_reset();
    launch(100, -1);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    tick_q.delete();
    done_q.delete();
    #1;
    vectors++;
    if ({tick, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_rst_flags: got tick/busy/done=%b, expected 000", {tick, busy, done});
    end
    vectors++;
    if (tick_cnt !== '0) begin miscompares++; $display("FAIL async_rst_cnt: got %0d, expected 0", tick_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    launch(1, -1);
    drain(40);
    vectors++;
    if (tick_cnt !== 8'd1) begin miscompares++; $display("FAIL async_post_cnt: got %0d, expected 1", tick_cnt); end
    vectors++;
    if (tick_q.size() + done_q.size() != 0) begin
      miscompares++;
      $display("FAIL async_post_pending: %0d events outstanding, expected 0", tick_q.size() + done_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_stop(5, 25, 2);
    test_stop(2, 20, 2);
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tick_burst_gen.md
# tick_burst_gen

Upstream stimulus stage for the behavioural counter blocks. It generates a programmable burst of single-cycle clock-enable ticks, evenly spaced every DIV clocks, and reports completion. A negedge-sampling counter consumes each `tick` as its increment event. This replaces free-running bench clock toggling with a bounded, restartable source that has a clean start/stop/done handshake.

## Interface
- `DIV`, 10, clock cycles between ticks; legal range ≥ 2.
- `CNT_W`, 8, width of the burst length and tick counter.

- `clk`  in  1  single clock; all flops on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level sampled each edge; accepted only in IDLE.
- `stop`  in  1  abort request; honoured only in RUN.
- `burst_len`  in  CNT_W  number of ticks to issue; sampled only when `start` is accepted.
- `tick`  out  1  registered one-cycle enable pulse.
- `busy`  out  1  high while in RUN.
- `done`  out  1  registered one-cycle completion pulse.
- `tick_cnt`  out  CNT_W  ticks issued in the current or most recent burst; holds after done.

## Operation
- Three states: IDLE, RUN, DONE.
- IDLE:
  - On `start`, latch `burst_len` into `len_q`, clear the prescaler and `tick_cnt`.
  - If `len_q` is 0, go to DONE; otherwise go to RUN.
  - `stop` is ignored in IDLE.
- RUN:
  - The prescaler counts 0..DIV-1 and wraps to 0.
  - When it reaches DIV-1, the block registers `tick`=1 for the next cycle and increments `tick_cnt`.
  - When the incremented `tick_cnt` equals `len_q`, go to DONE.
  - `start` is ignored in RUN; no restart occurs mid-burst.
- `stop` in RUN:
  - Go to DONE at the next edge; no further ticks.
  - A tick already registered in the same edge still appears.
  - `tick_cnt` freezes at the number of ticks actually issued.
- Simultaneous final tick and `stop`: the tick is issued, `tick_cnt`=`len_q`, and DONE is entered once (one `done` pulse).
- DONE: `done`=1 for exactly one cycle, then unconditional return to IDLE. `start` during DONE is ignored.
- Arithmetic:
  - `tick_cnt` never exceeds `len_q`, so no wrap is possible.
  - The prescaler is $clog2(DIV) bits wide and compares against the constant DIV-1.
- Reset (asynchronous, any state including mid-burst):
  - State goes to IDLE.
  - `tick`=0, `busy`=0, `done`=0, `tick_cnt`=0, prescaler=0, `len_q`=0.
  - Outputs drop immediately on `rst_n` assertion, not at the next edge.

## Timing
- Edge 0 is the rising edge where `start` is accepted.
- `busy` rises after edge 0 (len ≠ 0).
- Tick k (k = 1..len) is high during the cycle following edge k·DIV.
- `tick` is stable across the falling edge, so negedge consumers sample it safely.
- `tick_cnt` updates in the same cycle that `tick` is high.
- After the last tick:
  - `busy` falls in the same cycle that the last tick is high.
  - `done` is high in the cycle after that edge.
  - The block is back in IDLE one cycle later.
- Total burst latency, start to `done`: len·DIV + 1 cycles.
- len = 0: `done` is high in the cycle after edge 0; `busy` never rises; no ticks.
- Earliest restart: `start` accepted on the edge that exits DONE + 1. Back-to-back bursts are separated by 2 idle cycles.

## Structure
- Shared package `tick_pkg`:
  - state enum `tick_state_e` {IDLE, RUN, DONE};
  - default constants `TICK_DIV_DEF`=10 and `TICK_CNT_W_DEF`=8.
- Sub-module `tick_prescaler` (parameter DIV; ports `clk`, `rst_n`, `clr`, `en`, `wrap`). It is the natural reusable split. The FSM, `len_q`, and the output registers stay in the top.
- Elaboration check: fatal error if DIV < 2.

## Test plan
- Reset, then `start` with len=3, DIV=10:
  - ticks in the cycles after edges 10, 20, 30;
  - `tick_cnt` goes 1, 2, 3;
  - `done` high in the cycle after edge 31;
  - exactly 3 tick pulses.
- len=0 `start`: `done` high in the cycle after edge 0; zero ticks; `busy` never 1; `tick_cnt`=0.
- len=5, `stop` at edge 25: ticks at edges 10 and 20 only; `tick_cnt`=2; single `done` pulse.
- len=2, `stop` coincident with edge 20 (the final tick): tick issued, `tick_cnt`=2, one `done`.
- `start` pulsed mid-RUN and during DONE: ignored, with no change to `len_q` or timing. A restart on the first IDLE edge yields a fresh burst with `tick_cnt` reset to 0.
- Assert `rst_n`=0 asynchronously mid-prescale during a len=100 burst: all outputs 0 before the next edge. After release plus `start` len=1, a tick appears after edge 10.
